// File: rtl/sccb_write_master.sv
// SCCB 3-phase write master: START, four bytes each followed by an ACK slot, then STOP.
// All line changes are aligned to a quarter-SCL-period tick derived from CLK_DIV.
module sccb_write_master #(
    parameter int unsigned CLK_DIV = 312
) (
    input  logic        clk_25M,
    input  logic        camera_rst,
    input  logic        start,
    input  logic [31:0] i2c_data,
    output logic        busy,
    output logic        tr_end,
    output logic        ack,
    output logic        i2c_sclk,
    inout  wire         i2c_sdat
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_ACK,
        S_STOP,
        S_DONE
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [1:0]  qtr_q;
    logic [2:0]  bit_q;
    logic [1:0]  byte_q;
    logic [31:0] shreg_q;
    logic        ack_flag_q;
    logic        scl_q;
    logic        sda_low_q;
    logic        busy_q;
    logic        tr_end_q;
    logic        ack_q;
    logic [1:0]  sda_sync_q;
    logic        tick;

    assign tick     = (cnt_q == DIV_LAST);
    assign i2c_sdat = sda_low_q ? 1'b0 : 1'bz;
    assign i2c_sclk = scl_q;
    assign busy     = busy_q;
    assign tr_end   = tr_end_q;
    assign ack      = ack_q;

    always_ff @(posedge clk_25M or posedge camera_rst) begin
        if (camera_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            qtr_q      <= '0;
            bit_q      <= '0;
            byte_q     <= '0;
            shreg_q    <= '0;
            ack_flag_q <= 1'b0;
            scl_q      <= 1'b1;
            sda_low_q  <= 1'b0;
            busy_q     <= 1'b0;
            tr_end_q   <= 1'b0;
            ack_q      <= 1'b0;
            sda_sync_q <= 2'b11;
        end else begin
            // SDA comes from off-chip; two flops before the ACK decision
            sda_sync_q <= {sda_sync_q[0], i2c_sdat};
            tr_end_q   <= 1'b0;
            if (state_q inside {S_START, S_BIT, S_ACK, S_STOP})
                cnt_q <= tick ? '0 : cnt_q + 16'd1;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        shreg_q    <= i2c_data;
                        cnt_q      <= '0;
                        qtr_q      <= '0;
                        bit_q      <= '0;
                        byte_q     <= '0;
                        ack_flag_q <= 1'b1;
                        busy_q     <= 1'b1;
                        sda_low_q  <= 1'b1;
                        scl_q      <= 1'b1;
                        state_q    <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (qtr_q == 2'd0) begin
                            qtr_q <= 2'd1;
                            scl_q <= 1'b0;
                        end else begin
                            qtr_q     <= 2'd0;
                            sda_low_q <= ~shreg_q[31];
                            state_q   <= S_BIT;
                        end
                    end
                end
                S_BIT: begin
                    if (tick) begin
                        qtr_q <= qtr_q + 2'd1;
                        case (qtr_q)
                            2'd0: scl_q <= 1'b1;
                            2'd1: ;
                            2'd2: scl_q <= 1'b0;
                            default: begin
                                shreg_q <= {shreg_q[30:0], 1'b0};
                                bit_q   <= bit_q + 3'd1;
                                if (bit_q == 3'd7) begin
                                    sda_low_q <= 1'b0;
                                    state_q   <= S_ACK;
                                end else begin
                                    sda_low_q <= ~shreg_q[30];
                                end
                            end
                        endcase
                    end
                end
                S_ACK: begin
                    if (tick) begin
                        qtr_q <= qtr_q + 2'd1;
                        case (qtr_q)
                            2'd0: scl_q <= 1'b1;
                            2'd1: if (sda_sync_q[1]) ack_flag_q <= 1'b0;
                            2'd2: scl_q <= 1'b0;
                            default: begin
                                // a NACK skips any remaining bytes
                                if (!ack_flag_q || byte_q == 2'd3) begin
                                    sda_low_q <= 1'b1;
                                    state_q   <= S_STOP;
                                end else begin
                                    byte_q    <= byte_q + 2'd1;
                                    sda_low_q <= ~shreg_q[31];
                                    state_q   <= S_BIT;
                                end
                            end
                        endcase
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        qtr_q <= qtr_q + 2'd1;
                        case (qtr_q)
                            2'd0: scl_q <= 1'b1;
                            2'd1: sda_low_q <= 1'b0;
                            default: begin
                                qtr_q    <= 2'd0;
                                busy_q   <= 1'b0;
                                tr_end_q <= 1'b1;
                                ack_q    <= ack_flag_q;
                                state_q  <= S_DONE;
                            end
                        endcase
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sccb_write_master.sv
// Scoreboard bench: stimulus pushes expected transaction results, a negedge monitor with an
// embedded slave model and line-protocol checks pops and compares on every tr_end.
module tb_sccb_write_master;
    localparam int CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] data = '0;
    logic        busy, tr_end, ack, scl;
    wire         sda;
    logic        slv_drv = 1'b0;
    logic [3:0]  ack_mask = 4'hF;
    logic        chk_gap = 1'b0;

    assign sda = slv_drv ? 1'b0 : 1'bz;
    pullup pu_sda (sda);

    sccb_write_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk_25M   (clk),
        .camera_rst(rst),
        .start     (start),
        .i2c_data  (data),
        .busy      (busy),
        .tr_end    (tr_end),
        .ack       (ack),
        .i2c_sclk  (scl),
        .i2c_sdat  (sda)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ack_v;
        int          lat;
        int          nrx;
        logic [31:0] rx;
        int          rises;
    } exp_t;
    exp_t exp_q[$];

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input bit ok, input string name, input longint act, input longint expv);
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // monitor + slave model
    int cyc = 0, t_acc = 0, t_end = -100, last_edge = -1;
    int n_rise = 0, n_start = 0, n_stop = 0, nbit = 0, nbyte = 0, nrx = 0;
    logic [7:0]  rxsh = '0;
    logic [31:0] rxw = '0;
    logic scl_p = 1'b1, sda_p = 1'b1, busy_p = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                slv_drv = 1'b0; nbit = 0; nbyte = 0; n_rise = 0; n_start = 0; n_stop = 0;
                last_edge = -1; rxw = '0; nrx = 0;
            end else begin
                if (busy && !busy_p) begin
                    t_acc = cyc;
                    if (chk_gap) check(cyc - t_end == 2, "idle_gap", cyc - t_end, 2);
                end
                if (slv_drv) check(sda === 1'b0, "sda_driven_high", sda, 0);
                if (scl && scl_p && sda !== sda_p) begin
                    if (sda === 1'b0) begin n_start++; nbit = 0; nbyte = 0; end
                    else n_stop++;
                end
                if (scl !== scl_p) begin
                    if (last_edge >= 0)
                        check(cyc - last_edge == 2*CLK_DIV, "scl_phase", cyc - last_edge, 2*CLK_DIV);
                    last_edge = busy ? cyc : -1;
                    if (scl) begin
                        n_rise++;
                        if (nbit < 8) rxsh = {rxsh[6:0], (sda === 1'b0) ? 1'b0 : 1'b1};
                        nbit++;
                        if (nbit == 8) begin rxw = {rxw[23:0], rxsh}; nrx++; end
                    end else begin
                        if (nbit == 8) begin
                            if (nbyte < 4 && ack_mask[nbyte]) slv_drv = 1'b1;
                        end else if (nbit == 9) begin
                            slv_drv = 1'b0; nbit = 0; nbyte++;
                        end
                    end
                end
                if (tr_end) begin
                    check(exp_q.size() > 0, "tr_end_expected", exp_q.size(), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check(ack === e.ack_v, "ack", ack, e.ack_v);
                        check(cyc - t_acc + 1 == e.lat, "latency", cyc - t_acc + 1, e.lat);
                        check(nrx == e.nrx, "byte_count", nrx, e.nrx);
                        check(rxw == e.rx, "bytes", rxw, e.rx);
                        check(n_rise == e.rises, "scl_rises", n_rise, e.rises);
                        check(n_start == 1, "start_cond", n_start, 1);
                        check(n_stop == 1, "stop_cond", n_stop, 1);
                        check(busy == 1'b0, "busy_at_end", busy, 0);
                    end
                    n_rise = 0; n_start = 0; n_stop = 0; rxw = '0; nrx = 0;
                    last_edge = -1; t_end = cyc;
                end
            end
            scl_p = scl; sda_p = (sda === 1'b0) ? 1'b0 : 1'b1; busy_p = busy;
        end
    end

    task automatic push(input logic a, input int lat, input int n, input logic [31:0] rx, input int r);
        exp_t e;
        e.ack_v = a; e.lat = lat; e.nrx = n; e.rx = rx; e.rises = r;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        int w = 0;
        while ((busy || tr_end) && w < 2000) begin @(negedge clk); w++; end
        check(w < 2000, "idle_timeout", w, 2000);
    endtask

    task automatic run(input logic [31:0] d, input logic [3:0] m, input bit disturb);
        int w = 0;
        wait_idle();
        data = d; ack_mask = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (disturb) begin
            repeat (100) @(negedge clk);
            data = 32'hFFFF_FFFF; start = 1'b1;
            repeat (10) @(negedge clk);
            start = 1'b0;
        end
        while (!tr_end && w < 2000) begin @(negedge clk); w++; end
        check(w < 2000, "tr_end_timeout", w, 2000);
        @(negedge clk);
    endtask

    initial begin
        int w, seen;
        repeat (3) @(negedge clk);
        #1;
        check(scl == 1'b1, "rst_scl", scl, 1);
        check(sda === 1'b1, "rst_sda", sda, 1);
        check(busy == 1'b0, "rst_busy", busy, 0);
        check(tr_end == 1'b0, "rst_tr_end", tr_end, 0);
        check(ack == 1'b0, "rst_ack", ack, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // full write, with start/data disturbed while busy
        push(1'b1, 597, 4, 32'h78310311, 37);
        run(32'h78310311, 4'hF, 1'b1);
        // NACK on byte 1: 4*(2+72+3)+1
        push(1'b0, 309, 2, 32'h0000_7831, 19);
        run(32'h78310311, 4'b1101, 1'b0);
        // NACK on byte 0: 4*(2+36+3)+1
        push(1'b0, 165, 1, 32'h0000_0078, 10);
        run(32'h78310311, 4'b1110, 1'b0);
        // NACK on last byte: full length, ack=0
        push(1'b0, 597, 4, 32'h78310311, 37);
        run(32'h78310311, 4'b0111, 1'b0);

        // start held high across three transactions
        wait_idle();
        data = 32'h78310311; ack_mask = 4'hF;
        repeat (3) push(1'b1, 597, 4, 32'h78310311, 37);
        start = 1'b1;
        seen = 0; w = 0;
        while (seen < 3 && w < 3000) begin
            @(negedge clk); w++;
            if (tr_end) begin seen++; chk_gap = 1'b1; end
        end
        start = 1'b0;
        check(seen == 3, "b2b_tr_end_count", seen, 3);
        @(negedge clk);
        chk_gap = 1'b0;
        check(busy == 1'b0, "b2b_no_extra_accept", busy, 0);

        // reset during byte 2 (first bit, SCL low), no tr_end expected
        wait_idle();
        data = 32'h78310311; ack_mask = 4'hF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (297) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check(scl == 1'b1, "abort_scl", scl, 1);
        check(sda === 1'b1, "abort_sda", sda, 1);
        check(busy == 1'b0, "abort_busy", busy, 0);
        check(tr_end == 1'b0, "abort_tr_end", tr_end, 0);
        check(ack == 1'b0, "abort_ack", ack, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        push(1'b1, 597, 4, 32'h78300882, 37);
        run(32'h78300882, 4'hF, 1'b0);

        repeat (20) @(negedge clk);
        check(exp_q.size() == 0, "pending_expected", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
